// File: rtl/upc_loop_perf_monitor.sv
// upc_loop_perf_monitor: passive monitor for an HLS pipelined loop and its enclosing module.
// Counts issued/retired iterations, stalls, loop invocations, latencies and module transactions.
`default_nettype none

module upc_loop_perf_monitor #(
    parameter int STATE_W = 1,
    parameter int CNT_W   = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [STATE_W-1:0] cur_state,
    input  logic [STATE_W-1:0] iter_start_state,
    input  logic [STATE_W-1:0] iter_end_state,
    input  logic [STATE_W-1:0] quit_state,
    input  logic               iter_start_block,
    input  logic               iter_end_block,
    input  logic               quit_block,
    input  logic               iter_start_enable,
    input  logic               iter_end_enable,
    input  logic               quit_enable,
    input  logic               loop_start,
    input  logic               loop_ready,
    input  logic               loop_done,
    input  logic               loop_continue,
    input  logic               quit_at_end,
    input  logic               mod_start,
    input  logic               mod_ready,
    input  logic               mod_done,
    input  logic               mod_continue,
    input  logic               finish,
    output logic [CNT_W-1:0]   iter_start_cnt,
    output logic [CNT_W-1:0]   iter_end_cnt,
    output logic [CNT_W-1:0]   inflight_cnt,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   invoke_cnt,
    output logic [CNT_W-1:0]   last_latency,
    output logic [CNT_W-1:0]   max_latency,
    output logic [CNT_W-1:0]   mod_txn_cnt,
    output logic               loop_busy,
    output logic               mod_busy,
    output logic               frozen,
    output logic               proto_err
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == C_CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    logic             w_istart;
    logic             w_iend;
    logic             w_quit;
    logic             w_done_ev;
    logic             w_loop_start;
    logic             w_loop_end;
    logic             w_mod_start;
    logic             w_mod_end;
    logic             w_iend_err;
    logic             w_idle_done_err;
    logic [CNT_W-1:0] w_cur_lat;
    logic [CNT_W-1:0] r_lat_acc;
    logic             unused_taps;

    assign w_istart = iter_start_enable & ~iter_start_block & (cur_state == iter_start_state);
    assign w_iend   = iter_end_enable & ~iter_end_block & (cur_state == iter_end_state);
    assign w_quit   = quit_enable & ~quit_block & (cur_state == quit_state) & loop_done
                    & (~quit_at_end | w_iend);

    // A new start is accepted either from idle or in the very cycle the running invocation ends.
    assign w_done_ev    = loop_done & loop_continue;
    assign w_loop_start = loop_start & (~loop_busy | w_done_ev);
    assign w_loop_end   = w_done_ev & (loop_busy | w_loop_start);
    assign w_cur_lat    = loop_busy ? sat_inc(r_lat_acc) : CNT_W'(1);

    assign w_mod_start = mod_start & ~mod_busy;
    assign w_mod_end   = mod_done & mod_continue & (mod_busy | w_mod_start);

    // A retire paired with an issue in the same cycle is legal even with nothing in flight.
    assign w_iend_err      = w_iend & ~w_istart & (inflight_cnt == '0);
    assign w_idle_done_err = loop_done & ~loop_busy & ~loop_start;

    assign unused_taps = &{1'b0, mod_ready, loop_ready, w_quit};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            iter_start_cnt <= '0;
            iter_end_cnt   <= '0;
            inflight_cnt   <= '0;
            stall_cnt      <= '0;
            invoke_cnt     <= '0;
            last_latency   <= '0;
            max_latency    <= '0;
            mod_txn_cnt    <= '0;
            loop_busy      <= 1'b0;
            mod_busy       <= 1'b0;
            frozen         <= 1'b0;
            proto_err      <= 1'b0;
            r_lat_acc      <= '0;
        end else begin
            if (finish) frozen <= 1'b1;
            if (w_iend_err | w_idle_done_err) proto_err <= 1'b1;

            if (!frozen) begin
                if (w_istart) iter_start_cnt <= sat_inc(iter_start_cnt);
                if (w_iend)   iter_end_cnt   <= sat_inc(iter_end_cnt);

                if (w_istart & ~w_iend)
                    inflight_cnt <= sat_inc(inflight_cnt);
                else if (w_iend & ~w_istart & (inflight_cnt != '0))
                    inflight_cnt <= inflight_cnt - CNT_W'(1);

                if (loop_busy & iter_start_enable & iter_start_block)
                    stall_cnt <= sat_inc(stall_cnt);

                if (w_loop_start) invoke_cnt <= sat_inc(invoke_cnt);

                if (w_loop_end) begin
                    last_latency <= w_cur_lat;
                    if (w_cur_lat > max_latency) max_latency <= w_cur_lat;
                end

                if (w_loop_start) begin
                    loop_busy <= 1'b1;
                    r_lat_acc <= CNT_W'(1);
                end else if (w_loop_end) begin
                    loop_busy <= 1'b0;
                    r_lat_acc <= '0;
                end else if (loop_busy) begin
                    r_lat_acc <= w_cur_lat;
                end

                if (w_mod_end) begin
                    mod_busy    <= 1'b0;
                    mod_txn_cnt <= sat_inc(mod_txn_cnt);
                end else if (w_mod_start) begin
                    mod_busy <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_upc_loop_perf_monitor.sv
// tb_upc_loop_perf_monitor: scoreboard bench for upc_loop_perf_monitor.
// Each scenario pushes its expected statistics and drains them against the DUT outputs.
`default_nettype none

module tb_upc_loop_perf_monitor;

    logic        clock;
    logic        reset;
    logic [0:0]  cur_state, iter_start_state, iter_end_state, quit_state;
    logic        iter_start_block, iter_end_block, quit_block;
    logic        iter_start_enable, iter_end_enable, quit_enable;
    logic        loop_start, loop_ready, loop_done, loop_continue, quit_at_end;
    logic        mod_start, mod_ready, mod_done, mod_continue, finish;
    logic [31:0] iter_start_cnt, iter_end_cnt, inflight_cnt, stall_cnt;
    logic [31:0] invoke_cnt, last_latency, max_latency, mod_txn_cnt;
    logic        loop_busy, mod_busy, frozen, proto_err;

    upc_loop_perf_monitor #(.STATE_W(1), .CNT_W(32)) dut (
        .clock(clock), .reset(reset),
        .cur_state(cur_state), .iter_start_state(iter_start_state),
        .iter_end_state(iter_end_state), .quit_state(quit_state),
        .iter_start_block(iter_start_block), .iter_end_block(iter_end_block),
        .quit_block(quit_block), .iter_start_enable(iter_start_enable),
        .iter_end_enable(iter_end_enable), .quit_enable(quit_enable),
        .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
        .loop_continue(loop_continue), .quit_at_end(quit_at_end),
        .mod_start(mod_start), .mod_ready(mod_ready), .mod_done(mod_done),
        .mod_continue(mod_continue), .finish(finish),
        .iter_start_cnt(iter_start_cnt), .iter_end_cnt(iter_end_cnt),
        .inflight_cnt(inflight_cnt), .stall_cnt(stall_cnt), .invoke_cnt(invoke_cnt),
        .last_latency(last_latency), .max_latency(max_latency), .mod_txn_cnt(mod_txn_cnt),
        .loop_busy(loop_busy), .mod_busy(mod_busy), .frozen(frozen), .proto_err(proto_err)
    );

    typedef struct {
        string       sig;
        logic [31:0] exp;
    } sb_t;

    sb_t   sb_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    string cur_test = "none";
    string all_outs[12] = '{"iter_start_cnt", "iter_end_cnt", "inflight_cnt", "stall_cnt",
                            "invoke_cnt", "last_latency", "max_latency", "mod_txn_cnt",
                            "loop_busy", "mod_busy", "frozen", "proto_err"};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input string sig);
        case (sig)
            "iter_start_cnt": return iter_start_cnt;
            "iter_end_cnt":   return iter_end_cnt;
            "inflight_cnt":   return inflight_cnt;
            "stall_cnt":      return stall_cnt;
            "invoke_cnt":     return invoke_cnt;
            "last_latency":   return last_latency;
            "max_latency":    return max_latency;
            "mod_txn_cnt":    return mod_txn_cnt;
            "loop_busy":      return 32'(loop_busy);
            "mod_busy":       return 32'(mod_busy);
            "frozen":         return 32'(frozen);
            "proto_err":      return 32'(proto_err);
            default:          return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push(input string sig, input logic [31:0] exp);
        sb_t e;
        e.sig = sig;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk_eq({cur_test, ".", e.sig}, observe(e.sig), e.exp);
        end
    endtask

    task automatic push_all_zero();
        foreach (all_outs[i]) push(all_outs[i], 32'd0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        cur_state = '0; iter_start_state = '0; iter_end_state = '0; quit_state = '0;
        iter_start_block = 0; iter_end_block = 0; quit_block = 0;
        iter_start_enable = 0; iter_end_enable = 0; quit_enable = 0;
        loop_start = 0; loop_ready = 0; loop_done = 0; loop_continue = 0; quit_at_end = 0;
        mod_start = 0; mod_ready = 0; mod_done = 0; mod_continue = 0; finish = 0;
    endtask

    task automatic random_inputs();
        cur_state = 1'($urandom); iter_start_state = 1'($urandom);
        iter_end_state = 1'($urandom); quit_state = 1'($urandom);
        iter_start_block = 1'($urandom); iter_end_block = 1'($urandom);
        quit_block = 1'($urandom); iter_start_enable = 1'($urandom);
        iter_end_enable = 1'($urandom); quit_enable = 1'($urandom);
        loop_start = 1'($urandom); loop_ready = 1'($urandom); loop_done = 1'($urandom);
        loop_continue = 1'($urandom); quit_at_end = 1'($urandom);
        mod_start = 1'($urandom); mod_ready = 1'($urandom); mod_done = 1'($urandom);
        mod_continue = 1'($urandom); finish = 1'($urandom);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;

        // Reset held with random activity, then released with idle inputs.
        cur_test = "reset";
        for (int c = 0; c < 6; c++) begin
            random_inputs();
            step();
        end
        push_all_zero();
        drain();
        idle_inputs();
        reset = 1'b1;
        step();
        push_all_zero();
        drain();

        // Single 8-cycle invocation, one iteration issued and retired per cycle.
        cur_test = "basic";
        do_reset();
        for (int c = 1; c <= 8; c++) begin
            iter_start_enable = 1; iter_end_enable = 1;
            loop_start = (c == 1);
            loop_done = (c == 8); loop_continue = (c == 8);
            step();
        end
        idle_inputs();
        step();
        push("invoke_cnt", 1); push("iter_start_cnt", 8); push("iter_end_cnt", 8);
        push("inflight_cnt", 0); push("last_latency", 8); push("max_latency", 8);
        push("loop_busy", 0); push("stall_cnt", 0); push("proto_err", 0);
        drain();

        // Issue stage blocked for three busy cycles.
        cur_test = "stall";
        do_reset();
        for (int c = 1; c <= 8; c++) begin
            iter_start_enable = 1;
            iter_start_block = (c >= 2 && c <= 4);
            iter_end_enable = !(c >= 2 && c <= 4);
            loop_start = (c == 1);
            loop_done = (c == 8); loop_continue = (c == 8);
            step();
        end
        idle_inputs();
        step();
        push("stall_cnt", 3); push("iter_start_cnt", 5); push("iter_end_cnt", 5);
        push("inflight_cnt", 0); push("last_latency", 8); push("proto_err", 0);
        drain();

        // Back-to-back invocations: restart in the cycle of the first done.
        cur_test = "b2b";
        do_reset();
        for (int c = 1; c <= 11; c++) begin
            loop_start = (c <= 10);
            loop_done = (c == 8 || c == 11); loop_continue = (c == 8 || c == 11);
            step();
            if (c <= 10) begin
                push("loop_busy", 1);
                drain();
            end
        end
        idle_inputs();
        step();
        push("invoke_cnt", 2); push("last_latency", 4); push("max_latency", 8);
        push("loop_busy", 0); push("proto_err", 0);
        drain();

        // Retire with nothing in flight.
        cur_test = "iend_err";
        do_reset();
        iter_end_enable = 1;
        step();
        idle_inputs();
        step();
        push("proto_err", 1); push("inflight_cnt", 0); push("iter_end_cnt", 1);
        drain();

        // Done while idle with no start.
        cur_test = "done_err";
        do_reset();
        loop_done = 1;
        step();
        idle_inputs();
        step();
        push("proto_err", 1); push("loop_busy", 0); push("invoke_cnt", 0);
        drain();

        // Freeze in the middle of an invocation.
        cur_test = "freeze";
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            loop_start = (c == 1);
            iter_start_enable = 1;
            step();
        end
        idle_inputs();
        finish = 1;
        step();
        finish = 0;
        push("frozen", 1);
        drain();
        for (int c = 1; c <= 10; c++) begin
            iter_start_enable = 1;
            loop_start = (c == 3);
            loop_done = (c == 10); loop_continue = (c == 10);
            step();
        end
        idle_inputs();
        step();
        push("iter_start_cnt", 4); push("inflight_cnt", 4); push("invoke_cnt", 1);
        push("loop_busy", 1); push("last_latency", 0); push("frozen", 1);
        drain();

        // Module handshake, including a done held off by continue.
        cur_test = "module";
        do_reset();
        for (int c = 0; c < 20; c++) step();
        push("mod_txn_cnt", 0); push("mod_busy", 0);
        drain();
        for (int c = 1; c <= 7; c++) begin
            mod_start = (c == 1 || c == 5);
            mod_done = (c == 4 || c == 6 || c == 7);
            mod_continue = (c == 4 || c == 7);
            step();
            if (c == 1 || c == 6) begin
                push("mod_busy", 1);
                drain();
            end
            if (c == 4) begin
                push("mod_busy", 0); push("mod_txn_cnt", 1);
                drain();
            end
        end
        idle_inputs();
        step();
        push("mod_txn_cnt", 2); push("mod_busy", 0); push("loop_busy", 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
